// File: rtl/proc_pkg.sv
// proc_pkg: feeder state encoding, core opcodes and instruction field helpers.
package proc_pkg;
  typedef enum logic [2:0] {IDLE, FETCH_I, LATCH_I, LATCH_IMM, ISSUE, EXEC, NEXT, HALT} state_t;
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  function automatic logic [2:0] op_f(input logic [8:0] i);
    return i[8:6];
  endfunction
  function automatic logic [2:0] rx_f(input logic [8:0] i);
    return i[5:3];
  endfunction
  function automatic logic [2:0] ry_f(input logic [8:0] i);
    return i[2:0];
  endfunction
endpackage

// File: rtl/feeder_watchdog.sv
// feeder_watchdog: loadable down-counter; o_expired marks the last cycle of the Done wait budget.
module feeder_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= W'(TIMEOUT - 1);
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_expired = r_cnt == '0;
endmodule

// File: rtl/instr_feeder.sv
// instr_feeder: fetches 9-bit words from a synchronous ROM and feeds them to the core with a Run pulse.
// Build option FEEDER_SINGLE_STEP_EN adds a Step input; each advance out of NEXT then needs a Step rising edge.
module instr_feeder #(
  parameter int         ADDR_W       = 5,
  parameter int         PROG_LEN     = 32,
  parameter int         DONE_TIMEOUT = 15,
  parameter logic [2:0] OP_MVI       = proc_pkg::OP_MVI
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  output logic [ADDR_W-1:0] RomAddr,
  input  logic [8:0]        RomData,
  output logic [8:0]        DIN,
  output logic              Run,
  input  logic              Done,
`ifdef FEEDER_SINGLE_STEP_EN
  input  logic              Step,
`endif
  output logic              Busy,
  output logic              Halted,
  output logic              Fault,
  output logic [ADDR_W-1:0] PC
);
  import proc_pkg::*;
  localparam logic [ADDR_W:0] LEN = (ADDR_W+1)'(PROG_LEN);
  state_t r_state, w_next;
  logic [ADDR_W:0] r_pc;
  logic [ADDR_W-1:0] w_pc_lo;
  logic [8:0] r_ir, r_imm;
  logic r_fault, w_mvi, w_end, w_expired, w_advance;
  assign w_pc_lo = r_pc[ADDR_W-1:0];
  assign w_mvi = op_f(r_ir) == OP_MVI;
  // PC carries one extra bit so a wrap past the top of ROM still reads as "past the program"
  assign w_end = r_pc >= LEN;
`ifdef FEEDER_SINGLE_STEP_EN
  localparam state_t PARK = NEXT;
  logic r_step_q;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) r_step_q <= 1'b0;
    else r_step_q <= Step;
  assign w_advance = Step & ~r_step_q;
`else
  localparam state_t PARK = IDLE;
  assign w_advance = 1'b1;
`endif
  feeder_watchdog #(.TIMEOUT(DONE_TIMEOUT)) u_wd (
    .clk(Clock),
    .rst(Reset),
    .i_load(r_state == ISSUE),
    .i_en(r_state == EXEC),
    .o_expired(w_expired)
  );
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_imm   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == LATCH_I) r_ir <= RomData;
      if (r_state == LATCH_IMM) r_imm <= RomData;
      if (r_state == EXEC && Done) r_pc <= r_pc + (w_mvi ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));
      if (r_state == EXEC && !Done && w_expired) r_fault <= 1'b1;
    end
  always_comb begin
    w_next  = r_state;
    RomAddr = (r_state == LATCH_I && op_f(RomData) == OP_MVI) ? w_pc_lo + ADDR_W'(1) : w_pc_lo;
    DIN     = r_state == ISSUE ? r_ir : r_state == EXEC ? (w_mvi ? r_imm : r_ir) : '0;
    Run     = r_state == ISSUE;
    case (r_state)
      IDLE:      if (Start) w_next = w_end ? HALT : FETCH_I;
      FETCH_I:   w_next = LATCH_I;
      LATCH_I:   w_next = op_f(RomData) == OP_MVI ? LATCH_IMM : ISSUE;
      LATCH_IMM: w_next = ISSUE;
      ISSUE:     w_next = EXEC;
      EXEC:      w_next = Done ? NEXT : w_expired ? HALT : EXEC;
      NEXT:      w_next = w_end ? HALT : (Start && w_advance) ? FETCH_I : PARK;
      default:   w_next = r_state;
    endcase
  end
  assign Busy   = r_state != IDLE && r_state != HALT;
  assign Halted = r_state == HALT;
  assign Fault  = r_fault;
  assign PC     = w_pc_lo;
endmodule
